// File: rtl/iomem_ctrl.sv
// iomem_ctrl: shares one iomem bus window among four peripheral slots.
// Decodes iomem_addr, issues a one-cycle strobe to the selected slot, waits
// for its acknowledge and returns a one-cycle iomem_ready to the CPU.
// Optional watchdog: define IOMEM_CTRL_TIMEOUT_EN to force completion of
// transactions to slots that never acknowledge and record the error.
module iomem_ctrl #(
    parameter logic [13:0] ADDR    = 14'h1800,
    parameter logic [7:0]  TIMEOUT = 8'd255,
    parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         iomem_valid,
    input  logic [3:0]   iomem_wstrb,
    input  logic [31:0]  iomem_addr,
    input  logic [31:0]  iomem_wdata,
    output logic         iomem_ready,
    output logic [31:0]  iomem_rdata,
    output logic [3:0]   p_we,
    output logic [3:0]   p_re,
    output logic [15:0]  p_addr,
    output logic [31:0]  p_wdata,
    output logic [3:0]   p_wstrb,
    input  logic [3:0]   p_ready,
    input  logic [127:0] p_rdata,
    output logic         err,
    output logic [1:0]   err_slot,
    input  logic         err_clr
);

    localparam int unsigned DW    = 32;
    localparam int unsigned NSLOT = 4;
    localparam int unsigned SW    = 2;
    localparam int unsigned PAW   = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STROBE = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state_q, state_n;
    logic [SW-1:0]    slot_q, slot_n;
    logic             wr_q, wr_n;
    logic [PAW-1:0]   p_addr_n;
    logic [DW-1:0]    p_wdata_n;
    logic [3:0]       p_wstrb_n;
    logic [NSLOT-1:0] p_we_n, p_re_n;
    logic             ready_n;
    logic [DW-1:0]    rdata_n;

    logic             hit;
    logic [SW-1:0]    sel_slot;
    logic             ack;
    logic [DW-1:0]    slot_rdata;
    logic             expire;
    logic             to_evt;

    // Address decode and selected-slot views
    assign hit        = (iomem_addr[31:18] == ADDR);
    assign sel_slot   = iomem_addr[17:16];
    assign ack        = p_ready[slot_q];
    assign slot_rdata = p_rdata[{slot_q, 5'd0} +: DW];

`ifdef IOMEM_CTRL_TIMEOUT_EN
    localparam int unsigned CW = 8;

    logic [CW-1:0] cnt_q, cnt_n;
    logic          err_n;
    logic [SW-1:0] err_slot_n;

    assign expire = (cnt_q == (TIMEOUT - 8'd1));
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign err        = 1'b0;
    assign err_slot   = '0;
    assign unused_cfg = ^{err_clr, TIMEOUT, to_evt};
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_n   = state_q;
        slot_n    = slot_q;
        wr_n      = wr_q;
        p_addr_n  = p_addr;
        p_wdata_n = p_wdata;
        p_wstrb_n = p_wstrb;
        p_we_n    = '0;
        p_re_n    = '0;
        ready_n   = 1'b0;
        rdata_n   = iomem_rdata;
        to_evt    = 1'b0;

        case (state_q)
            IDLE: begin
                rdata_n = '0;
                if (iomem_valid && hit) begin
                    state_n   = STROBE;
                    slot_n    = sel_slot;
                    wr_n      = |iomem_wstrb;
                    p_addr_n  = iomem_addr[15:0];
                    p_wdata_n = iomem_wdata;
                    p_wstrb_n = iomem_wstrb;
                    if (|iomem_wstrb) begin
                        p_we_n = 4'b0001 << sel_slot;
                    end else begin
                        p_re_n = 4'b0001 << sel_slot;
                    end
                end
            end
            STROBE, WAIT: begin
                // Acknowledge takes priority over watchdog expiry
                if (ack) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                    rdata_n = wr_q ? '0 : slot_rdata;
                end else if (expire) begin
                    state_n = DONE;
                    ready_n = 1'b1;
                    rdata_n = wr_q ? '0 : TO_DATA;
                    to_evt  = 1'b1;
                end else begin
                    state_n = WAIT;
                end
            end
            DONE: begin
                state_n = IDLE;
                rdata_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

`ifdef IOMEM_CTRL_TIMEOUT_EN
        if (state_q == IDLE) begin
            cnt_n = '0;
        end else if ((state_q == STROBE) || (state_q == WAIT)) begin
            cnt_n = cnt_q + CW'(1);
        end else begin
            cnt_n = cnt_q;
        end
        // A new timeout beats a simultaneous clear
        err_n      = (err & ~err_clr) | to_evt;
        err_slot_n = to_evt ? slot_q : err_slot;
`endif
    end

    // State and output registers
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            wr_q        <= 1'b0;
            p_addr      <= '0;
            p_wdata     <= '0;
            p_wstrb     <= '0;
            p_we        <= '0;
            p_re        <= '0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
        end else begin
            state_q     <= state_n;
            slot_q      <= slot_n;
            wr_q        <= wr_n;
            p_addr      <= p_addr_n;
            p_wdata     <= p_wdata_n;
            p_wstrb     <= p_wstrb_n;
            p_we        <= p_we_n;
            p_re        <= p_re_n;
            iomem_ready <= ready_n;
            iomem_rdata <= rdata_n;
        end
    end

`ifdef IOMEM_CTRL_TIMEOUT_EN
    // Watchdog counter and sticky error registers
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            err      <= 1'b0;
            err_slot <= '0;
        end else begin
            cnt_q    <= cnt_n;
            err      <= err_n;
            err_slot <= err_slot_n;
        end
    end
`endif

endmodule

// File: doc/iomem_ctrl.md
# iomem_ctrl

Sequencer for the Risc-V iomem bus that shares one CPU bus window among four peripheral slots. It decodes the address and issues a single-cycle write or read strobe to the selected slot. It then waits for that slot's acknowledge, captures read data and returns a one-cycle `iomem_ready` to the CPU. An optional watchdog completes transactions to slots that never acknowledge and records the error.

## Interface
Parameters:
- `ADDR`, 14'h1800: match value for `iomem_addr[31:18]`. With the default, the window is 0x6000_0000–0x6003_FFFF.
- `TIMEOUT`, 8'd255: cycles spent in STROBE+WAIT before forced completion. Legal range is 2..255.
- `TO_DATA`, 32'hDEAD_BEEF: `iomem_rdata` value returned on a timed-out read.

Ports:
- `ck` in 1: clock. All state updates on the posedge.
- `rst` in 1: asynchronous, active-low reset.
- `iomem_valid` in 1: CPU request.
- `iomem_wstrb` in 4: byte enables. Non-zero means write; zero means read.
- `iomem_addr` in 32: CPU address.
- `iomem_wdata` in 32: CPU write data.
- `iomem_ready` out 1: transaction complete. High for exactly one cycle.
- `iomem_rdata` out 32: read data. Valid while `iomem_ready` is high.
- `p_we` out 4: one-hot write strobe per slot.
- `p_re` out 4: one-hot read strobe per slot.
- `p_addr` out 16: registered `iomem_addr[15:0]`.
- `p_wdata` out 32: registered write data.
- `p_wstrb` out 4: registered byte enables.
- `p_ready` in 4: per-slot acknowledge.
- `p_rdata` in 128: per-slot read data. Slot n uses bits [32n+31:32n].
- `err` out 1: sticky timeout flag.
- `err_slot` out 2: slot index of the most recent timeout.
- `err_clr` in 1: clears `err`.

## Operation
- Slot select is `iomem_addr[17:16]`. A request hits only when `iomem_addr[31:18] == ADDR`.
- A miss is ignored: no strobe, no ready. Another decoder owns that address.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE → STROBE: on a hit with `iomem_valid` high. On that edge, latch slot, direction, `p_addr`, `p_wdata` and `p_wstrb`.
- STROBE lasts one cycle. During it, exactly one bit of `p_we` or `p_re` is high.
- STROBE/WAIT → DONE: when `p_ready[slot]` is high.
  - On a read, capture `p_rdata[slot]` into `iomem_rdata` on this transition.
  - On a write, `iomem_rdata` is 0.
- Otherwise STROBE → WAIT, and WAIT holds.
- DONE asserts `iomem_ready` for one cycle, then goes to IDLE unconditionally. IDLE does not accept a request in the same cycle DONE exits.
- `p_ready` bits of non-selected slots are ignored in every state.
- Reset values: state IDLE; all outputs 0; `err_slot` 0.

## Timing
- With `iomem_valid` sampled at edge 0:
  - strobe high in cycle 0–1;
  - if `p_ready` is high during STROBE, `iomem_ready` is high in cycle 1–2;
  - minimum latency is 2 edges.
- Each extra cycle of peripheral delay adds one cycle of latency.
- `p_addr`, `p_wdata` and `p_wstrb` stay stable from STROBE through DONE.
- `iomem_valid` dropping mid-transaction is a CPU protocol violation. The transaction still completes and `iomem_ready` still pulses.
- Async reset during any state forces IDLE immediately and kills strobes and ready mid-cycle.
- `err_clr` and a new timeout in the same cycle: the set wins.

## Configuration
- `IOMEM_CTRL_TIMEOUT_EN` defined:
  - an 8-bit counter clears on entry to STROBE and increments in STROBE and WAIT;
  - when the count reaches `TIMEOUT - 1` with no acknowledge, go to DONE;
  - `iomem_rdata` = `TO_DATA` for reads, 0 for writes;
  - `err` is set and `err_slot` is loaded with the slot;
  - an acknowledge in the same cycle as expiry wins: normal completion, no error.
- Macro not defined: no counter; WAIT holds indefinitely; `err` and `err_slot` are tied to 0; `err_clr` is unused.

## Test plan
- Read, zero wait: addr 0x6002_0010, wstrb 0; slot 2 acks during STROBE with rdata 0x1234_5678 → `p_re` = 4'b0100 for 1 cycle, `p_addr` = 0x0010, `iomem_ready` pulses 2 edges after valid, `iomem_rdata` = 0x1234_5678.
- Write, slot 1 acks after 5 wait cycles: addr 0x6001_0004, wstrb 4'hF, wdata 0xA5A5_A5A5 → `p_we` = 4'b0010 for exactly 1 cycle, `p_wdata` held until ready, ready on edge 7.
- Miss: addr 0x5000_0000 and 0x6004_0000 → no strobe, no ready, FSM stays IDLE. Acks on non-selected slots mid-transaction → ignored.
- Timeout (macro on, `TIMEOUT` = 16): read slot 3, no ack → ready after 16 cycles in STROBE+WAIT, rdata 0xDEAD_BEEF, `err` = 1, `err_slot` = 3. Ack on the expiry cycle in a rerun → no error. Simultaneous `err_clr` and new timeout → `err` stays 1.
- Reset mid-WAIT: drive `rst` low asynchronously → all outputs 0 immediately; after release, a new read completes normally.
- Back-to-back: valid re-asserted on the cycle after ready → second transaction starts from IDLE with no double strobe.
